// File: rtl/fp32_mul_ctrl.sv
// fp32 multiply sequencer: unpacks operands, drives the integer multiplier, normalizes/rounds/packs.
// Latency: 2 cycles on the special-operand path, multiplier latency + 5 on the normal path.
// No backpressure: start is sampled only in IDLE and ignored while busy; FP_MUL_RNE_EN selects RNE over truncation.
module fp32_mul_ctrl #(
   parameter int MUL_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [31:0]        a,
   input  logic [31:0]        b,
   output logic [31:0]        result,
   output logic               done,
   output logic               busy,
   output logic               flag_invalid,
   output logic               flag_overflow,
   output logic               flag_underflow,
   output logic               flag_inexact,
   output logic               mul_start,
   output logic [MUL_W-1:0]   mul_a,
   output logic [MUL_W-1:0]   mul_b,
   input  logic [2*MUL_W-1:0] mul_product,
   input  logic               mul_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_UNPACK, S_ISSUE, S_WAIT, S_NORM, S_ROUND, S_DONE
   } state_t;

   state_t            state, state_nxt;

   logic [31:0]       a_q, b_q;
   logic              sign_q;
   logic signed [9:0] exp_q;
   logic [23:0]       m_q;
   logic              g_q, s_q;

   // Operand fields; exponent 0 covers both zero and flushed subnormals
   logic [7:0]        ea, eb;
   logic [22:0]       fa, fb;
   logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic              special, sign_ab;
   logic [31:0]       spec_res;
   logic              spec_inv;
   logic [47:0]       prod;

   assign ea      = a_q[30:23];
   assign eb      = b_q[30:23];
   assign fa      = a_q[22:0];
   assign fb      = b_q[22:0];
   assign nan_a   = (ea == 8'hFF) && (fa != 23'd0);
   assign nan_b   = (eb == 8'hFF) && (fb != 23'd0);
   assign inf_a   = (ea == 8'hFF) && (fa == 23'd0);
   assign inf_b   = (eb == 8'hFF) && (fb == 23'd0);
   assign zero_a  = (ea == 8'h00);
   assign zero_b  = (eb == 8'h00);
   assign special = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
   assign sign_ab = a_q[31] ^ b_q[31];
   assign prod    = mul_product[47:0];

   // Upper product bits never carry information for 24-bit significands
   generate
      if (MUL_W > 24) begin : g_unused_hi
         logic unused_hi;
         assign unused_hi = ^mul_product[2*MUL_W-1:48];
      end
   endgenerate

   // Resolve special operand combinations without using the multiplier
   always_comb begin
      spec_res = 32'd0;
      spec_inv = 1'b0;
      if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
         spec_res = 32'h7FC0_0000;
         spec_inv = 1'b1;
      end else if (inf_a || inf_b) begin
         spec_res = {sign_ab, 8'hFF, 23'd0};
      end else begin
         spec_res = {sign_ab, 31'd0};
      end
   end

   // Rounding, post-round renormalization and range check
   logic              round_up;
   logic [24:0]       m_sum;
   logic signed [9:0] e_rnd;
   logic [22:0]       frac_rnd;
   logic              rnd_ovf, rnd_unf, rnd_inx;
   logic [31:0]       rnd_res;

`ifdef FP_MUL_RNE_EN
   assign round_up = g_q & (s_q | m_q[0]);
`else
   assign round_up = 1'b0;
`endif

   assign m_sum    = {1'b0, m_q} + {24'd0, round_up};
   assign e_rnd    = exp_q + $signed({9'd0, m_sum[24]});
   assign frac_rnd = m_sum[24] ? m_sum[23:1] : m_sum[22:0];
   assign rnd_ovf  = (e_rnd >= 10'sd255);
   assign rnd_unf  = !rnd_ovf && (e_rnd <= 10'sd0);
   assign rnd_inx  = rnd_ovf | rnd_unf | g_q | s_q;

   // Pack the rounded result, saturating to Inf or flushing to zero
   always_comb begin
      rnd_res = {sign_q, e_rnd[7:0], frac_rnd};
      if (rnd_ovf) begin
         rnd_res = {sign_q, 8'hFF, 23'd0};
      end else if (rnd_unf) begin
         rnd_res = {sign_q, 31'd0};
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_UNPACK;
         S_UNPACK: state_nxt = special ? S_DONE : S_ISSUE;
         S_ISSUE:  state_nxt = S_WAIT;
         S_WAIT:   if (mul_done) state_nxt = S_NORM;
         S_NORM:   state_nxt = S_ROUND;
         S_ROUND:  state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State-decoded control outputs
   always_comb begin
      busy      = (state != S_IDLE);
      mul_start = (state == S_ISSUE);
      done      = (state == S_DONE);
   end

   // Datapath: operand capture, exponent, normalization and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q            <= 32'd0;
         b_q            <= 32'd0;
         sign_q         <= 1'b0;
         exp_q          <= 10'sd0;
         m_q            <= 24'd0;
         g_q            <= 1'b0;
         s_q            <= 1'b0;
         mul_a          <= '0;
         mul_b          <= '0;
         result         <= 32'd0;
         flag_invalid   <= 1'b0;
         flag_overflow  <= 1'b0;
         flag_underflow <= 1'b0;
         flag_inexact   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_q            <= a;
                  b_q            <= b;
                  flag_invalid   <= 1'b0;
                  flag_overflow  <= 1'b0;
                  flag_underflow <= 1'b0;
                  flag_inexact   <= 1'b0;
               end
            end
            S_UNPACK: begin
               sign_q <= sign_ab;
               if (special) begin
                  result         <= spec_res;
                  flag_invalid   <= spec_inv;
                  flag_overflow  <= 1'b0;
                  flag_underflow <= 1'b0;
                  flag_inexact   <= 1'b0;
               end else begin
                  exp_q <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
                  mul_a <= MUL_W'({1'b1, fa});
                  mul_b <= MUL_W'({1'b1, fb});
               end
            end
            S_NORM: begin
               if (prod[47]) begin
                  m_q   <= prod[47:24];
                  g_q   <= prod[23];
                  s_q   <= |prod[22:0];
                  exp_q <= exp_q + 10'sd1;
               end else begin
                  m_q <= prod[46:23];
                  g_q <= prod[22];
                  s_q <= |prod[21:0];
               end
            end
            S_ROUND: begin
               result         <= rnd_res;
               flag_invalid   <= 1'b0;
               flag_overflow  <= rnd_ovf;
               flag_underflow <= rnd_unf;
               flag_inexact   <= rnd_inx;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_mul_ctrl.sv
// Bench for fp32_mul_ctrl: behavioural sequential multiplier plus an arithmetic reference model.
// Checks result, flags, latency and multiplier handshake for directed and random operands.
// Start is only driven when the DUT is idle, except for the deliberate mid-operation pulse.
module tb_fp32_mul_ctrl;

   localparam int MUL_W    = 32;
   localparam int SPEC_LAT = 2;
   localparam int NORM_LAT = 39;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic [31:0]        op_a = 32'd0;
   logic [31:0]        op_b = 32'd0;
   logic [31:0]        result;
   logic               done, busy;
   logic               flag_invalid, flag_overflow, flag_underflow, flag_inexact;
   logic               mul_start;
   logic [MUL_W-1:0]   mul_a, mul_b;
   logic [2*MUL_W-1:0] mul_product;
   logic               mul_done;

   int n_checks = 0;
   int n_fail   = 0;
   int mul_pulses = 0;
   int mcnt;

   fp32_mul_ctrl #(.MUL_W(MUL_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .a              (op_a),
      .b              (op_b),
      .result         (result),
      .done           (done),
      .busy           (busy),
      .flag_invalid   (flag_invalid),
      .flag_overflow  (flag_overflow),
      .flag_underflow (flag_underflow),
      .flag_inexact   (flag_inexact),
      .mul_start      (mul_start),
      .mul_a          (mul_a),
      .mul_b          (mul_b),
      .mul_product    (mul_product),
      .mul_done       (mul_done)
   );

   always #5 clk = ~clk;

   // Sequential multiplier stand-in: done rises MUL_W+1 edges after accept, cleared on accept
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_done    <= 1'b0;
         mul_product <= '0;
         mcnt        <= 0;
      end else if (mul_start) begin
         mul_done    <= 1'b0;
         mul_product <= 64'(mul_a) * 64'(mul_b);
         mcnt        <= MUL_W + 1;
         mul_pulses  <= mul_pulses + 1;
      end else if (mcnt == 1) begin
         mul_done <= 1'b1;
         mcnt     <= 0;
      end else if (mcnt > 1) begin
         mcnt <= mcnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Exact-product reference: flags packed as {invalid, overflow, underflow, inexact}
   function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic [3:0] fl,
                                   output bit sp);
      int ex, ey, e, sh;
      bit nx, ny, ix, iy, zx, zy, up;
      logic s;
      logic [63:0] p, m, rem, half;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      s  = x[31] ^ y[31];
      nx = (ex == 255) && (x[22:0] != 0);
      ny = (ey == 255) && (y[22:0] != 0);
      ix = (ex == 255) && (x[22:0] == 0);
      iy = (ey == 255) && (y[22:0] == 0);
      zx = (ex == 0);
      zy = (ey == 0);
      sp = nx | ny | ix | iy | zx | zy;
      fl = 4'b0000;
      r  = 32'd0;
      if (nx || ny || (ix && zy) || (zx && iy)) begin
         r  = 32'h7FC0_0000;
         fl = 4'b1000;
      end else if (ix || iy) begin
         r = {s, 8'hFF, 23'd0};
      end else if (zx || zy) begin
         r = {s, 31'd0};
      end else begin
         p  = {40'd0, 1'b1, x[22:0]} * {40'd0, 1'b1, y[22:0]};
         e  = ex + ey - 127;
         sh = (p >= 64'h8000_0000_0000) ? 24 : 23;
         if (sh == 24) e++;
         m    = p >> sh;
         rem  = p - (m << sh);
         half = 64'd1 << (sh - 1);
`ifdef FP_MUL_RNE_EN
         up = (rem > half) || ((rem == half) && m[0]);
`else
         up = 1'b0;
`endif
         m = m + 64'(up);
         if (m == (64'd1 << 24)) begin
            m = m >> 1;
            e++;
         end
         if (e >= 255) begin
            r  = {s, 8'hFF, 23'd0};
            fl = 4'b0101;
         end else if (e <= 0) begin
            r  = {s, 31'd0};
            fl = 4'b0011;
         end else begin
            r  = {s, 8'(e), m[22:0]};
            fl = {3'b000, rem != 0};
         end
      end
   endfunction

   // One full operation; glitch_at > 0 pulses start (with junk operands) in that cycle
   task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input int glitch_at);
      logic [31:0] er;
      logic [3:0]  ef;
      bit          sp;
      int          n, p0;
      ref_mul(xa, xb, er, ef, sp);
      p0 = mul_pulses;
      @(negedge clk);
      start = 1'b1;
      op_a  = xa;
      op_b  = xb;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      n = 1;
      while (!done && n < 200) begin
         if (n == glitch_at) begin
            start = 1'b1;
            op_a  = $urandom;
            op_b  = $urandom;
         end
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      chk("latency", 32'(n), sp ? 32'(SPEC_LAT) : 32'(NORM_LAT));
      chk("result", result, er);
      chk("flags", {28'd0, flag_invalid, flag_overflow, flag_underflow, flag_inexact}, {28'd0, ef});
      chk("mul_start_count", 32'(mul_pulses - p0), sp ? 32'd0 : 32'd1);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_after_done", 32'(busy), 32'd0);
   endtask

   function automatic logic [31:0] rand_op();
      int k, j;
      logic [7:0]  e;
      logic [22:0] f;
      logic        sg;
      k  = $urandom_range(0, 11);
      f  = 23'($urandom);
      sg = 1'($urandom);
      e  = 8'($urandom_range(90, 165));
      if (k == 0) begin
         j = $urandom_range(0, 3);
         case (j)
            0:       return {sg, 31'd0};
            1:       return {sg, 8'hFF, 23'd0};
            2:       return {sg, 8'hFF, f | 23'd1};
            default: return {sg, 8'h00, f | 23'd1};
         endcase
      end else if (k == 1) begin
         e = 8'($urandom_range(1, 30));
      end else if (k == 2) begin
         e = 8'($urandom_range(225, 254));
      end
      return {sg, e, f};
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_result", result, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flags", {28'd0, flag_invalid, flag_overflow, flag_underflow, flag_inexact}, 32'd0);
      chk("rst_mul_start", 32'(mul_start), 32'd0);
      chk("rst_mul_a", mul_a, 32'd0);
      chk("rst_mul_b", mul_b, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Directed cases with hand-computed expectations
      run_op(32'h3FC0_0000, 32'h4000_0000, 0);
      chk("dir_1p5x2", result, 32'h4040_0000);
      run_op(32'hC040_0000, 32'h3F00_0000, 0);
      chk("dir_m3x0p5", result, 32'hBFC0_0000);
      run_op(32'h3F80_0001, 32'h3FC0_0000, 0);
`ifdef FP_MUL_RNE_EN
      chk("dir_tie", result, 32'h3FC0_0002);
`else
      chk("dir_tie", result, 32'h3FC0_0001);
`endif
      chk("dir_tie_inexact", 32'(flag_inexact), 32'd1);
      run_op(32'h7F80_0000, 32'h0000_0000, 0);
      chk("dir_inf_x_zero", result, 32'h7FC0_0000);
      chk("dir_inf_x_zero_inv", 32'(flag_invalid), 32'd1);
      run_op(32'h7F7F_FFFF, 32'h4000_0000, 0);
      chk("dir_overflow", result, 32'h7F80_0000);
      chk("dir_overflow_flag", 32'(flag_overflow), 32'd1);
      run_op(32'h0080_0000, 32'h3F00_0000, 0);
      chk("dir_underflow", result, 32'h0000_0000);
      chk("dir_underflow_flag", 32'(flag_underflow), 32'd1);

      // start pulsed during WAIT must not disturb the running operation
      run_op(32'h3FC0_0000, 32'h4000_0000, 10);
      chk("glitch_result", result, 32'h4040_0000);

      // Asynchronous reset in the middle of WAIT
      @(negedge clk);
      start = 1'b1;
      op_a  = 32'h4040_0000;
      op_b  = 32'h4040_0000;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_flags", {28'd0, flag_invalid, flag_overflow, flag_underflow, flag_inexact}, 32'd0);
      chk("midrst_mul_start", 32'(mul_start), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_op(32'h3FC0_0000, 32'h4000_0000, 0);
      chk("post_rst_1p5x2", result, 32'h4040_0000);

      // Randomized operands against the reference model
      for (int i = 0; i < 40; i++) begin
         run_op(rand_op(), rand_op(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp32_mul_ctrl.md
# fp32_mul_ctrl

Sequencing controller for IEEE-754 single-precision multiplication built around the team's sequential integer multiplier. It unpacks two fp32 operands and resolves special cases directly. For normal operands it issues the 24-bit significands to the integer multiplier and waits for its completion, then normalizes, rounds and packs the fp32 result. It sits directly upstream of the multiplier, which it feeds, and directly downstream of it, consuming its product.

## Interface
- `MUL_W`, 32: operand width of the attached integer multiplier; must be ≥ 24.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`, `b`  in  32  fp32 operands; captured on the edge that accepts `start`.
- `result`  out  32  fp32 product; reset 0; updated on entry to DONE, held until next update.
- `done`  out  1  one-cycle completion pulse; reset 0.
- `busy`  out  1  high in every state except IDLE; reset 0.
- `flag_invalid`, `flag_overflow`, `flag_underflow`, `flag_inexact`  out  1 each  exception flags; reset 0; updated together with `result`.
- `mul_start`  out  1  start to multiplier; reset 0; high only in ISSUE.
- `mul_a`, `mul_b`  out  MUL_W  zero-extended significands {1, frac}; reset 0.
- `mul_product`  in  2*MUL_W  multiplier product; bits [47:0] are significant.
- `mul_done`  in  1  multiplier completion level.

## Operation
- States: IDLE, UNPACK, ISSUE, WAIT, NORM, ROUND, DONE.
- IDLE: `start`=1 → capture `a`/`b` → UNPACK. `start` in any other state is ignored.
- UNPACK: classify each operand as NaN, Inf, zero or normal. Subnormal inputs are flushed to zero.
- Special cases go UNPACK→DONE and never touch the multiplier:
  - any NaN, or Inf×0 → 0x7FC00000, `flag_invalid`=1.
  - Inf×finite-nonzero → signed Inf.
  - zero×finite → signed zero.
  - Sign = sa^sb, except for NaN.
- Normal case: UNPACK computes exponent e = ea+eb−127 (10-bit signed) → ISSUE.
- ISSUE: `mul_start`=1 for exactly one cycle → WAIT. The multiplier clears its `done` on the accepting edge, so a stale `mul_done` from a previous operation is never seen in WAIT.
- WAIT: hold until `mul_done`=1 → NORM.
- NORM, selected by p[47]:
  - p[47]=1: m=p[47:24], G=p[23], S=|p[22:0], e+=1.
  - p[47]=0: m=p[46:23], G=p[22], S=|p[21:0].
- ROUND: round-up decision per Configuration. If m overflows to 2^24 → m>>=1, e+=1.
  - e ≥ 255 → signed Inf, `flag_overflow`=1, `flag_inexact`=1.
  - e ≤ 0 → signed zero, `flag_underflow`=1, `flag_inexact`=1.
  - Otherwise `flag_inexact` = G|S.
- DONE: `done`=1 → IDLE. Flags are cleared at each new accept, never accumulated.

## Timing
- Edge 0 accepts `start`; `busy` is high from the cycle after edge 0 until DONE completes.
- Special path: DONE after edge 1; `done` is high in cycle 2. Latency is 2 cycles.
- Normal path:
  - ISSUE after edge 1; the multiplier accepts on edge 2.
  - If `mul_done` is first sampled high on edge k: NORM after k, ROUND after k+1, DONE after k+2.
  - With `MUL_W`=32, k = 36 and `done` is high in cycle 39.
- Back-to-back: the next `start` is accepted at the earliest on the edge ending DONE+1, i.e. in IDLE.
- Reset mid-operation returns to IDLE immediately and zeroes all outputs. The multiplier's reset must be driven as `~rst` so both blocks reset together.

## Configuration
- `FP_MUL_RNE_EN` defined: round-to-nearest-even; increment when G & (S | m[0]).
- `FP_MUL_RNE_EN` undefined: truncation (round toward zero); never increment. `flag_inexact` is still G|S, and overflow saturates to Inf.

## Test plan
- 0x3FC00000 × 0x40000000 (1.5×2.0) → `result`=0x40400000, all flags 0, `done` one cycle, exactly one `mul_start` pulse.
- 0xC0400000 × 0x3F000000 (−3.0×0.5) → 0xBFC00000.
- 0x3F800001 × 0x3FC00000 (a tie case):
  - with `FP_MUL_RNE_EN` → 0x3FC00002;
  - without it → 0x3FC00001;
  - `flag_inexact`=1 in both builds.
- Special cases:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, `flag_invalid`=1, `done` 2 cycles after accept, `mul_start` never asserted.
  - 0x7F7FFFFF × 0x40000000 → 0x7F800000, `flag_overflow`=1.
  - 0x00800000 × 0x3F000000 → 0x00000000, `flag_underflow`=1.
- Control boundaries:
  - `start` pulsed during WAIT → ignored; the original result completes unchanged.
  - `rst`=0 during WAIT → `busy`, `done`, `result` and flags are 0 immediately.
  - After reset release, 1.5×2.0 still yields 0x40400000.
